// File: rtl/mc_mem_responder.sv
// Wait-state memory responder for the multicycle ARM datapath: latches a word
// request, stalls WAIT_CYCLES cycles, performs the RAM access, then pulses Ready.
module mc_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        Req,
  input  logic        MemW,
  input  logic [31:0] Adr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Ready,
  output logic        Busy,
  output logic        Err,
  output logic [1:0]  State
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [31:0]         ladr_q;
  logic [31:0]         lwd_q;
  logic                lmemw_q;
  logic [31:0]         rd_q;
  logic                ready_q;
  logic                err_q;
  logic                busy_q;
  logic [31:0]         mem_q [DEPTH];

  logic                addr_ok;
  logic [ADDR_W-1:0]   idx;

  always_comb begin
    addr_ok = (ladr_q[1:0] == 2'b00) && (ladr_q[31:ADDR_W+2] == '0);
    idx     = ladr_q[ADDR_W+1:2];
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (Req) begin
            ladr_q  <= Adr;
            lwd_q   <= WD;
            lmemw_q <= MemW;
            cnt_q   <= WAIT_INIT;
            busy_q  <= 1'b1;
            state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (!lmemw_q) rd_q <= addr_ok ? mem_q[idx] : '0;
          ready_q <= 1'b1;
          err_q   <= !addr_ok;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM is never cleared; a reset on the ACCESS edge suppresses the write.
  always_ff @(posedge CLK) begin
    if (RESET_N && (state_q == S_ACCESS) && lmemw_q && addr_ok)
      mem_q[idx] <= lwd_q;
  end

  assign RD    = rd_q;
  assign Ready = ready_q;
  assign Err   = err_q;
  assign Busy  = busy_q;
  assign State = state_q;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Directed bench for mc_mem_responder: one instance with 2 wait states, one with none.
module tb_mc_mem_responder;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        MemW = 1'b0;
  logic [31:0] Adr = '0, WD = '0;
  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1, busy0, busy1, err0, err1;
  logic [1:0]  st0, st1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  mc_mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) u0 (
    .CLK(CLK), .RESET_N(RESET_N), .Req(req0), .MemW(MemW), .Adr(Adr), .WD(WD),
    .RD(rd0), .Ready(rdy0), .Busy(busy0), .Err(err0), .State(st0)
  );

  mc_mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) u1 (
    .CLK(CLK), .RESET_N(RESET_N), .Req(req1), .MemW(MemW), .Adr(Adr), .WD(WD),
    .RD(rd1), .Ready(rdy1), .Busy(busy1), .Err(err1), .State(st1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called and returns on a falling edge; requester holds operands until Ready.
  task automatic do_acc(input bit sel, input logic mw, input logic [31:0] a, input logic [31:0] w,
                        output logic [31:0] rd, output logic er, output int lat);
    logic rdy;
    MemW = mw; Adr = a; WD = w;
    if (sel) req1 = 1'b1; else req0 = 1'b1;
    lat = 0; rdy = 1'b0;
    while (!rdy && lat < 20) begin
      @(posedge CLK); @(negedge CLK);
      lat++;
      rdy = sel ? rdy1 : rdy0;
    end
    rd = sel ? rd1 : rd0;
    er = sel ? err1 : err0;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, gap, nrdy;

    repeat (2) @(negedge CLK);
    check("rst_state", 32'(st0), 32'd0);
    check("rst_ready", 32'(rdy0), 32'd0);
    check("rst_busy",  32'(busy0), 32'd0);
    check("rst_err",   32'(err0), 32'd0);
    check("rst_rd",    rd0, 32'h0);
    check("rst_rd_w0", rd1, 32'h0);
    RESET_N = 1'b1;
    @(negedge CLK);

    do_acc(0, 1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("wr10_lat", 32'(lat), 32'd4);
    check("wr10_err", 32'(er), 32'd0);
    do_acc(0, 0, 32'h10, 32'h0, rd, er, lat);
    check("rd10_lat", 32'(lat), 32'd4);
    check("rd10_rd",  rd, 32'hDEADBEEF);
    check("rd10_err", 32'(er), 32'd0);

    do_acc(0, 0, 32'h13, 32'h0, rd, er, lat);
    check("mis_rd_err", 32'(er), 32'd1);
    check("mis_rd_rd",  rd, 32'h0);
    do_acc(0, 1, 32'h12, 32'h1234, rd, er, lat);
    check("mis_wr_err", 32'(er), 32'd1);
    do_acc(0, 0, 32'h10, 32'h0, rd, er, lat);
    check("after_mis_rd", rd, 32'hDEADBEEF);

    do_acc(0, 1, 32'h0, 32'h11112222, rd, er, lat);
    do_acc(0, 1, 32'h400, 32'h00000099, rd, er, lat);
    check("oor_wr_err", 32'(er), 32'd1);
    do_acc(0, 0, 32'h0, 32'h0, rd, er, lat);
    check("oor_rd0", rd, 32'h11112222);
    check("oor_rd0_err", 32'(er), 32'd0);

    // Operands scrambled every cycle after acceptance.
    MemW = 1'b1; Adr = 32'h18; WD = 32'hCAFEF00D; req0 = 1'b1;
    @(posedge CLK); @(negedge CLK);
    check("wait_state", 32'(st0), 32'd1);
    check("wait_busy",  32'(busy0), 32'd1);
    MemW = 1'b0; Adr = 32'h0; WD = 32'h55555555;
    @(posedge CLK); @(negedge CLK);
    MemW = 1'b1; Adr = 32'h13; WD = 32'hAAAAAAAA;
    @(posedge CLK); @(negedge CLK);
    check("access_state", 32'(st0), 32'd2);
    MemW = 1'b0; Adr = 32'h800;
    @(posedge CLK); @(negedge CLK);
    check("scr_ready", 32'(rdy0), 32'd1);
    check("scr_err",   32'(err0), 32'd0);
    check("done_state", 32'(st0), 32'd3);
    req0 = 1'b0;
    @(negedge CLK);
    do_acc(0, 0, 32'h18, 32'h0, rd, er, lat);
    check("scr_rd18", rd, 32'hCAFEF00D);
    do_acc(0, 0, 32'h0, 32'h0, rd, er, lat);
    check("scr_rd0", rd, 32'h11112222);

    // Back-to-back reads with Req held.
    do_acc(0, 1, 32'h14, 32'h55667788, rd, er, lat);
    MemW = 1'b0; Adr = 32'h10; req0 = 1'b1;
    lat = 0;
    do begin @(posedge CLK); @(negedge CLK); lat++; end while (!rdy0 && lat < 20);
    check("b2b_lat1", 32'(lat), 32'd4);
    check("b2b_rd1",  rd0, 32'hDEADBEEF);
    Adr = 32'h14;
    gap = 0;
    do begin @(posedge CLK); @(negedge CLK); gap++; end while (!rdy0 && gap < 20);
    check("b2b_gap", 32'(gap), 32'd5);
    check("b2b_rd2", rd0, 32'h55667788);
    req0 = 1'b0;
    @(negedge CLK);

    // Reset during WAIT abandons the write.
    do_acc(0, 1, 32'h20, 32'h0BADF00D, rd, er, lat);
    MemW = 1'b1; Adr = 32'h20; WD = 32'hFFFFFFFF; req0 = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RESET_N = 1'b0; req0 = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("midrst_state", 32'(st0), 32'd0);
    check("midrst_busy",  32'(busy0), 32'd0);
    RESET_N = 1'b1;
    nrdy = 0;
    repeat (6) begin @(posedge CLK); @(negedge CLK); if (rdy0) nrdy++; end
    check("midrst_noready", 32'(nrdy), 32'd0);
    do_acc(0, 0, 32'h20, 32'h0, rd, er, lat);
    check("midrst_rd20", rd, 32'h0BADF00D);

    // Zero wait states.
    MemW = 1'b1; Adr = 32'h20; WD = 32'h12345678; req1 = 1'b1;
    @(posedge CLK); @(negedge CLK);
    check("w0_state", 32'(st1), 32'd2);
    @(posedge CLK); @(negedge CLK);
    check("w0_wr_ready", 32'(rdy1), 32'd1);
    req1 = 1'b0;
    @(negedge CLK);
    do_acc(1, 0, 32'h20, 32'h0, rd, er, lat);
    check("w0_rd_lat", 32'(lat), 32'd2);
    check("w0_rd", rd, 32'h12345678);
    check("w0_err", 32'(er), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
